// File: rtl/neureka_tcdm_splitter_if.sv
// Wide HCI-style initiator bus and MP narrow 32-bit TCDM ports of the splitter.
// One instance carries both sides; the modports select the view.
interface neureka_tcdm_splitter_if #(
  parameter int unsigned BW = 288,
  parameter int unsigned MP = BW / 32
);
  logic                 wide_req;
  logic                 wide_gnt;
  logic [31:0]          wide_add;
  logic                 wide_wen;
  logic [BW/8-1:0]      wide_be;
  logic [BW-1:0]        wide_data;
  logic [BW-1:0]        wide_r_data;
  logic                 wide_r_valid;

  logic [MP-1:0]        tcdm_req;
  logic [MP-1:0]        tcdm_gnt;
  logic [MP-1:0][31:0]  tcdm_add;
  logic [MP-1:0]        tcdm_wen;
  logic [MP-1:0][3:0]   tcdm_be;
  logic [MP-1:0][31:0]  tcdm_data;
  logic [MP-1:0][31:0]  tcdm_r_data;
  logic [MP-1:0]        tcdm_r_valid;

  modport wide_master (
    output wide_req, wide_add, wide_wen, wide_be, wide_data,
    input  wide_gnt, wide_r_data, wide_r_valid
  );
  modport wide_slave (
    input  wide_req, wide_add, wide_wen, wide_be, wide_data,
    output wide_gnt, wide_r_data, wide_r_valid
  );
  modport tcdm_master (
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );
  modport tcdm_slave (
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );
endinterface

// File: rtl/neureka_tcdm_splitter.sv
// Splits one wide TCDM request into MP independently granted 32-bit requests and
// realigns the per-lane read responses through small fall-through FIFOs.
module neureka_tcdm_splitter #(
  parameter int unsigned BW         = 288,
  parameter int unsigned MP         = BW / 32,
  parameter int unsigned DEPTH      = 2,
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  neureka_tcdm_splitter_if.wide_slave        wide,
  neureka_tcdm_splitter_if.tcdm_master       tcdm,
  output logic                               busy_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 2);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  logic                       live_s;
  logic                       stall_s;
  logic                       gnt_s;
  logic                       rvalid_s;
  logic [MP-1:0]              active_s;
  logic [MP-1:0]              req_s;
  logic [MP-1:0]              fire_s;
  logic [MP-1:0]              accept_s;
  logic [MP-1:0]              nonempty_s;
  logic [MP-1:0]              avail_s;
  logic [MP-1:0]              push_s;
  logic [MP-1:0]              pop_s;
  logic [MP-1:0]              full_s;
  logic [MP-1:0][31:0]        head_s;
  logic [BW-1:0]              head_flat_s;

  logic [MP-1:0]              granted_r;
  logic [CW-1:0]              outstanding_r;
  logic [MP-1:0][CW-1:0]      pend_r;
  logic [MP-1:0][CW-1:0]      cnt_r;
  logic [MP-1:0][PW-1:0]      wr_ptr_r;
  logic [MP-1:0][PW-1:0]      rd_ptr_r;
  logic [MP-1:0][DEPTH-1:0][31:0] mem_r;

  // Reset or clear silences every request-side output in the same cycle.
  assign live_s  = rst_ni & ~clear_i;
  assign stall_s = wide.wide_wen & (outstanding_r == CW'(DEPTH));
  assign req_s   = {MP{live_s & wide.wide_req & ~stall_s}} & active_s & ~granted_r;
  assign gnt_s   = live_s & wide.wide_req & ~stall_s & (&(granted_r | tcdm.tcdm_gnt | ~active_s));
  assign fire_s  = req_s & tcdm.tcdm_gnt;

  // Lane activity, lane mapping and per-lane response availability.
  always_comb begin
    head_flat_s = '0;
    for (int i = 0; i < MP; i++) begin
      if (wide.wide_wen) begin
        active_s[i] = 1'b1;
      end else if (SKIP_EMPTY) begin
        active_s[i] = |wide.wide_be[4*i +: 4];
      end else begin
        active_s[i] = 1'b1;
      end
      tcdm.tcdm_add[i]  = wide.wide_add + 32'(4 * i);
      tcdm.tcdm_be[i]   = wide.wide_be[4*i +: 4];
      tcdm.tcdm_data[i] = wide.wide_data[32*i +: 32];
      tcdm.tcdm_wen[i]  = wide.wide_wen;
      // A response only counts if this lane still owes one; stale ones vanish.
      accept_s[i]   = live_s & tcdm.tcdm_r_valid[i] & (pend_r[i] != CW'(0));
      nonempty_s[i] = (cnt_r[i] != CW'(0));
      full_s[i]     = (cnt_r[i] == CW'(DEPTH));
      avail_s[i]    = nonempty_s[i] | accept_s[i];
      if (nonempty_s[i]) begin
        head_s[i] = mem_r[i][rd_ptr_r[i]];
      end else begin
        head_s[i] = tcdm.tcdm_r_data[i];
      end
      head_flat_s[32*i +: 32] = head_s[i];
    end
  end

  assign rvalid_s = live_s & (&avail_s);
  assign pop_s    = {MP{rvalid_s}} & nonempty_s;
  assign push_s   = accept_s & ~({MP{rvalid_s}} & ~nonempty_s);

  assign wide.wide_gnt     = gnt_s;
  assign wide.wide_r_valid = rvalid_s;
  assign wide.wide_r_data  = rvalid_s ? head_flat_s : '0;
  assign tcdm.tcdm_req     = req_s;
  assign busy_o = live_s & (wide.wide_req | (|granted_r) | (outstanding_r != CW'(0)));

  // Lanes already granted for the open wide request; a wide grant retires them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted_r <= '0;
    end else if (clear_i || gnt_s) begin
      granted_r <= '0;
    end else begin
      granted_r <= granted_r | fire_s;
    end
  end

  // Wide reads accepted but not yet delivered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_r <= '0;
    end else if (clear_i) begin
      outstanding_r <= '0;
    end else if ((gnt_s & wide.wide_wen) && !rvalid_s) begin
      outstanding_r <= outstanding_r + CW'(1);
    end else if (rvalid_s && !(gnt_s & wide.wide_wen)) begin
      outstanding_r <= outstanding_r - CW'(1);
    end
  end

  // Per-lane FIFO pointers/occupancy and count of narrow reads still owed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      pend_r   <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      pend_r   <= '0;
    end else begin
      for (int i = 0; i < MP; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
        if (pop_s[i])  rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
        if (push_s[i] && !pop_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end else if (pop_s[i] && !push_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CW'(1);
        end
        if ((fire_s[i] & wide.wide_wen) && !accept_s[i]) begin
          pend_r[i] <= pend_r[i] + CW'(1);
        end else if (accept_s[i] && !(fire_s[i] & wide.wide_wen)) begin
          pend_r[i] <= pend_r[i] - CW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= tcdm.tcdm_r_data[i];
    end
  end

  neureka_tcdm_splitter_chk #(.MP(MP)) u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept_s),
    .pop    (pop_s),
    .full   (full_s)
  );
endmodule

// Protocol checker: a response must never land on a full lane FIFO that is not draining.
module neureka_tcdm_splitter_chk #(
  parameter int unsigned MP = 9
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic [MP-1:0] push,
  input logic [MP-1:0] pop,
  input logic [MP-1:0] full
);
  for (genvar i = 0; i < MP; i++) begin : g_ovf
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push[i] && full[i] && !pop[i]));
  end
endmodule

// File: tb/tb_neureka_tcdm_splitter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_neureka_tcdm_splitter;
  localparam int BW    = 288;
  localparam int MP    = BW / 32;
  localparam int DEPTH = 2;

  logic clk     = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;
  logic busy_o;

  always #5 clk = ~clk;

  neureka_tcdm_splitter_if #(.BW(BW), .MP(MP)) bus ();

  neureka_tcdm_splitter #(.BW(BW), .MP(MP), .DEPTH(DEPTH), .SKIP_EMPTY(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .wide    (bus),
    .tcdm    (bus),
    .busy_o  (busy_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit auto_resp = 1'b0;
  bit stop_new  = 1'b0;

  // Model: lanes served for the open request, reads owed per lane, per-lane response queues.
  logic [MP-1:0] served;
  int            out_cnt;
  int            owed[MP];
  logic [31:0]   rq[MP][$];
  int            due[MP][$];
  logic          last_gnt;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] lanes(input logic [31:0] base);
    logic [BW-1:0] v;
    for (int i = 0; i < MP; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic model_reset();
    served   = '0;
    out_cnt  = 0;
    last_gnt = 1'b0;
    for (int i = 0; i < MP; i++) begin
      owed[i] = 0;
      rq[i].delete();
      due[i].delete();
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: mid-cycle check of every output, then advance the model.
  always @(negedge clk) begin : compare
    logic [MP-1:0] act_l, exp_req;
    logic          stall, exp_gnt, exp_rv, exp_busy;
    logic [BW-1:0] exp_rd, exp_add;
    if (!rst_ni || clear_i) begin
      chk("quiet_outs", BW'({bus.wide_gnt, bus.wide_r_valid, bus.tcdm_req, busy_o}), '0);
      chk("quiet_rdata", bus.wide_r_data, '0);
      model_reset();
    end else begin
      for (int i = 0; i < MP; i++)
        act_l[i] = bus.wide_wen ? 1'b1 : (bus.wide_be[4*i +: 4] != 4'h0);
      stall    = bus.wide_wen && (out_cnt == DEPTH);
      exp_req  = (bus.wide_req && !stall) ? (act_l & ~served) : '0;
      exp_gnt  = bus.wide_req && !stall && ((act_l & ~served & ~bus.tcdm_gnt) == '0);
      exp_busy = bus.wide_req || (served != '0) || (out_cnt != 0);
      for (int i = 0; i < MP; i++) begin
        if (bus.tcdm_r_valid[i] && owed[i] > 0) begin
          rq[i].push_back(bus.tcdm_r_data[i]);
          owed[i]--;
        end
      end
      exp_rv = 1'b1;
      exp_rd = '0;
      for (int i = 0; i < MP; i++) begin
        if (rq[i].size() == 0) exp_rv = 1'b0;
        exp_add[32*i +: 32] = bus.wide_add + 32'(4 * i);
      end
      if (exp_rv) for (int i = 0; i < MP; i++) exp_rd[32*i +: 32] = rq[i][0];

      chk("tcdm_req", BW'(bus.tcdm_req), BW'(exp_req));
      chk("wide_gnt", BW'(bus.wide_gnt), BW'(exp_gnt));
      chk("wide_r_valid", BW'(bus.wide_r_valid), BW'(exp_rv));
      chk("wide_r_data", bus.wide_r_data, exp_rd);
      chk("busy", BW'(busy_o), BW'(exp_busy));
      chk("tcdm_add", BW'(bus.tcdm_add), exp_add);
      chk("tcdm_be", BW'(bus.tcdm_be), BW'(bus.wide_be));
      chk("tcdm_data", BW'(bus.tcdm_data), bus.wide_data);
      chk("tcdm_wen", BW'(bus.tcdm_wen), BW'({MP{bus.wide_wen}}));

      for (int i = 0; i < MP; i++) begin
        if (exp_req[i] && bus.tcdm_gnt[i] && bus.wide_wen) begin
          owed[i]++;
          if (auto_resp) due[i].push_back(cyc + int'($urandom_range(1, 4)));
        end
      end
      if (exp_gnt) served = '0;
      else         served = served | (exp_req & bus.tcdm_gnt);
      if (exp_gnt && bus.wide_wen) out_cnt++;
      if (exp_rv) begin
        out_cnt--;
        for (int i = 0; i < MP; i++) void'(rq[i].pop_front());
      end
      last_gnt = exp_gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wide_req     = 1'b0;
    bus.tcdm_gnt     = '0;
    bus.tcdm_r_valid = '0;
  endtask

  task automatic wide_rd(input logic [31:0] a);
    bus.wide_req = 1'b1;
    bus.wide_wen = 1'b1;
    bus.wide_add = a;
    bus.wide_be  = '1;
  endtask

  task automatic resp(input logic [MP-1:0] v, input logic [31:0] base);
    bus.tcdm_r_valid = v;
    for (int i = 0; i < MP; i++) bus.tcdm_r_data[i] = base + 32'(i);
  endtask

  task automatic rand_drive();
    if (!bus.wide_req || last_gnt) begin
      if (!stop_new && $urandom_range(0, 9) < 7) begin
        bus.wide_req = 1'b1;
        bus.wide_wen = 1'($urandom_range(0, 1));
        bus.wide_add = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        case ($urandom_range(0, 3))
          0: bus.wide_be = '1;
          1: bus.wide_be = '0;
          2: for (int i = 0; i < BW / 8; i++) bus.wide_be[i] = 1'($urandom_range(0, 1));
          default: begin
            bus.wide_be = '0;
            bus.wide_be[4 * $urandom_range(0, MP - 1) +: 4] = 4'hF;
          end
        endcase
        for (int i = 0; i < MP; i++) bus.wide_data[32*i +: 32] = $urandom;
      end else begin
        bus.wide_req = 1'b0;
      end
    end
    bus.tcdm_gnt = (stop_new || $urandom_range(0, 3) == 0) ? '1 : MP'($urandom);
    for (int i = 0; i < MP; i++) begin
      bus.tcdm_r_data[i] = $urandom;
      if (due[i].size() > 0 && due[i][0] <= cyc) begin
        bus.tcdm_r_valid[i] = 1'b1;
        void'(due[i].pop_front());
      end else begin
        bus.tcdm_r_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit idle;
    int n;
    bus.wide_req = 1'b0; bus.wide_wen = 1'b0; bus.wide_add = '0; bus.wide_be = '0;
    bus.wide_data = '0; bus.tcdm_gnt = '0; bus.tcdm_r_valid = '0; bus.tcdm_r_data = '0;

    // Reset held with a pending request: outputs must stay quiet.
    step(); wide_rd(32'h0); bus.tcdm_gnt = '1; #2;
    chk("reset_outs", BW'({bus.wide_gnt, bus.wide_r_valid, bus.tcdm_req, busy_o}), '0);
    step(); rst_ni = 1'b1; idle_in();
    step(); clear_i = 1'b1; wide_rd(32'h40); bus.tcdm_gnt = '1; #2;
    chk("clear_gnt", BW'(bus.wide_gnt), '0);
    chk("clear_req", BW'(bus.tcdm_req), '0);
    step(); clear_i = 1'b0; idle_in();

    // All lanes granted together.
    step(); wide_rd(32'h1000); bus.tcdm_gnt = '1; #2;
    chk("t1_gnt", BW'(bus.wide_gnt), BW'(1'b1));
    chk("t1_req", BW'(bus.tcdm_req), BW'(9'h1FF));
    chk("t1_add8", BW'(bus.tcdm_add[8]), BW'(32'h1020));
    step(); idle_in(); resp('1, 32'hA0); #2;
    chk("t1_rv", BW'(bus.wide_r_valid), BW'(1'b1));
    chk("t1_data", bus.wide_r_data, lanes(32'hA0));
    step(); idle_in(); #2;
    chk("t1_rv_off", BW'(bus.wide_r_valid), '0);

    // Staggered grants.
    step(); wide_rd(32'h2000); bus.tcdm_gnt = 9'h00F; #2;
    chk("t2_req0", BW'(bus.tcdm_req), BW'(9'h1FF));
    chk("t2_gnt0", BW'(bus.wide_gnt), '0);
    step(); bus.tcdm_gnt = '0; resp(9'h00F, 32'hB0); #2;
    chk("t2_req1", BW'(bus.tcdm_req), BW'(9'h1F0));
    chk("t2_rv1", BW'(bus.wide_r_valid), '0);
    step(); bus.tcdm_r_valid = '0; bus.tcdm_gnt = 9'h1F0; #2;
    chk("t2_gnt2", BW'(bus.wide_gnt), BW'(1'b1));
    step(); idle_in(); resp(9'h1F0, 32'hB0); #2;
    chk("t2_rv3", BW'(bus.wide_r_valid), BW'(1'b1));
    chk("t2_data", bus.wide_r_data, lanes(32'hB0));

    // Sparse and empty writes.
    step(); idle_in(); bus.wide_req = 1'b1; bus.wide_wen = 1'b0; bus.wide_add = 32'h3000;
    bus.wide_be = 36'h00F; #2;
    chk("t3_req", BW'(bus.tcdm_req), BW'(9'h001));
    chk("t3_gnt0", BW'(bus.wide_gnt), '0);
    step(); bus.tcdm_gnt = 9'h001; #2;
    chk("t3_gnt", BW'(bus.wide_gnt), BW'(1'b1));
    step(); bus.tcdm_gnt = '0; bus.wide_be = '0; #2;
    chk("t3_zero_gnt", BW'(bus.wide_gnt), BW'(1'b1));
    chk("t3_zero_req", BW'(bus.tcdm_req), '0);

    // Outstanding limit.
    step(); idle_in(); wide_rd(32'h4000); bus.tcdm_gnt = '1; #2;
    chk("t4_g1", BW'(bus.wide_gnt), BW'(1'b1));
    step(); wide_rd(32'h4040); #2;
    chk("t4_g2", BW'(bus.wide_gnt), BW'(1'b1));
    step(); wide_rd(32'h4080); #2;
    chk("t4_stall_gnt", BW'(bus.wide_gnt), '0);
    chk("t4_stall_req", BW'(bus.tcdm_req), '0);
    step(); resp('1, 32'hC0); #2;
    chk("t4_rv", BW'(bus.wide_r_valid), BW'(1'b1));
    chk("t4_d1", bus.wide_r_data, lanes(32'hC0));
    chk("t4_still_stalled", BW'(bus.wide_gnt), '0);
    step(); bus.tcdm_r_valid = '0; #2;
    chk("t4_g3", BW'(bus.wide_gnt), BW'(1'b1));
    step(); idle_in(); resp('1, 32'hD0); #2;
    chk("t4_d2", bus.wide_r_data, lanes(32'hD0));
    step(); idle_in(); resp('1, 32'hE0); #2;
    chk("t4_d3", bus.wide_r_data, lanes(32'hE0));

    // Lane 5 responses arrive three cycles late for two reads.
    step(); idle_in(); wide_rd(32'h5000); bus.tcdm_gnt = '1;
    step(); wide_rd(32'h5040);
    step(); idle_in(); resp(9'h1DF, 32'h10);
    step(); idle_in(); resp(9'h1DF, 32'h20); #2;
    chk("t5_rv_a", BW'(bus.wide_r_valid), '0);
    step(); idle_in(); #2;
    chk("t5_rv_b", BW'(bus.wide_r_valid), '0);
    step(); idle_in(); resp(9'h020, 32'h10); #2;
    chk("t5_rv1", BW'(bus.wide_r_valid), BW'(1'b1));
    chk("t5_d1", bus.wide_r_data, lanes(32'h10));
    step(); idle_in(); resp(9'h020, 32'h20); #2;
    chk("t5_d2", bus.wide_r_data, lanes(32'h20));

    // Asynchronous reset with five lanes granted, then a late response and a fresh read.
    step(); idle_in(); wide_rd(32'h6000); bus.tcdm_gnt = 9'h01F;
    step(); bus.tcdm_gnt = '0; #2;
    chk("t6_req", BW'(bus.tcdm_req), BW'(9'h1E0));
    rst_ni = 1'b0; #1;
    chk("t6_rst_outs", BW'({bus.wide_gnt, bus.wide_r_valid, bus.tcdm_req, busy_o}), '0);
    step(); step(); rst_ni = 1'b1; idle_in(); resp(9'h001, 32'hDEAD);
    step(); idle_in(); wide_rd(32'h6100); bus.tcdm_gnt = '1; #2;
    chk("t6_gnt", BW'(bus.wide_gnt), BW'(1'b1));
    chk("t6_rv_none", BW'(bus.wide_r_valid), '0);
    step(); idle_in(); resp('1, 32'h30); #2;
    chk("t6_data", bus.wide_r_data, lanes(32'h30));
    step(); idle_in();

    // Random traffic, then drain.
    auto_resp = 1'b1;
    repeat (3000) begin
      step();
      rand_drive();
    end
    stop_new = 1'b1;
    idle = 1'b0;
    n = 0;
    while (!idle && n < 300) begin
      step();
      rand_drive();
      n++;
      idle = !bus.wide_req && (out_cnt == 0);
      for (int i = 0; i < MP; i++) if (due[i].size() != 0) idle = 1'b0;
    end
    chk("drain_idle", BW'(idle), BW'(1'b1));
    step(); idle_in(); #2;
    chk("final_busy", BW'(busy_o), '0);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
